// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and its transmitter sibling:
//   - rx_state_e   : receiver FSM states
//   - PARITY_*     : parity mode encodings for the PARITY parameter
//   - clog2()      : counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StPar,
      StStop,
      StCommit
   } rx_state_e;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   // Bits needed to hold 0..value-1; minimum 1 so DIV=1 still gets a vector.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider: counts 0..DIV-1 and asserts o_tick on the last count.
// i_clr restarts the count so the tick phase can be aligned to an event.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   i_clr   in  synchronous clear of the divider count
//   o_tick  out one-cycle pulse each time the count wraps
// -----------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned    CW   = clog2(DIV);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// Oversampling UART receiver with configurable data width, parity and stop
// bits. Received words are presented on a valid/ready handshake together with
// parity and framing flags; a frame finishing while the previous word is still
// unaccepted is dropped and reported with a one-cycle overrun pulse.
// Optional build macro: UART_RX_MAJORITY_EN -- each bit is the 2-of-3 vote of
// the line at ticks mid-1, mid, mid+1 (decided at mid+1) instead of a single
// sample at mid.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   rx_in      in  asynchronous serial line, idle high
//   data_out   out received word, LSB received first
//   valid      out data_out and flags valid, held until accepted
//   ready      in  consumer accepts when valid && ready
//   parity_err out parity mismatch for the word in data_out
//   frame_err  out a stop bit was sampled low for that word
//   overrun    out one-cycle pulse when a completed frame is dropped
//   busy       out receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 16000000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int unsigned DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
   localparam int unsigned OSW = clog2(OVERSAMPLE);
   localparam int unsigned BCW = clog2(WIDTH + 1);
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned SAMPLE_PT = OVERSAMPLE / 2;
`else
   localparam int unsigned SAMPLE_PT = OVERSAMPLE / 2 - 1;
`endif
   // Start bit is judged at the sample point counted from the edge; every
   // later bit is judged a full bit period after the previous decision.
   localparam logic [OSW-1:0] START_PT  = OSW'(SAMPLE_PT);
   localparam logic [OSW-1:0] BIT_PT    = OSW'(OVERSAMPLE - 1);
   localparam logic [BCW-1:0] LAST_DATA = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   logic             r_sync1, r_sync2, r_rx_prev;
   rx_state_e        r_state;
   logic [OSW-1:0]   r_os_cnt;
   logic [BCW-1:0]   r_bit_cnt;
   logic [WIDTH-1:0] r_shift;
   logic             r_par, r_pe, r_fe;

   logic w_rx_s, w_fall, w_tick, w_clr, w_sample, w_bit;

   assign w_rx_s = r_sync2;
   assign w_fall = r_rx_prev & ~w_rx_s;
   assign w_clr  = (r_state == StIdle) && w_fall;
   assign w_sample = w_tick &&
                     (r_os_cnt == ((r_state == StStart) ? START_PT : BIT_PT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx_in;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Line values at the two ticks preceding the decision tick.
   logic [1:0] r_vote;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vote <= 2'b11;
      end else if (w_tick) begin
         r_vote <= {r_vote[0], w_rx_s};
      end
   end

   assign w_bit = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rx_s) | (r_vote[0] & w_rx_s);
`else
   assign w_bit = w_rx_s;
`endif

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_os_cnt   <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_pe       <= 1'b0;
         r_fe       <= 1'b0;
         data_out   <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (valid && ready) valid <= 1'b0;

         if ((r_state != StIdle) && (r_state != StCommit) && w_tick) begin
            r_os_cnt <= w_sample ? '0 : r_os_cnt + 1'b1;
         end

         unique case (r_state)
            StIdle: begin
               // Edge-triggered: a line held low (break) never restarts.
               if (w_fall) begin
                  r_os_cnt  <= '0;
                  r_bit_cnt <= '0;
                  r_par     <= 1'b0;
                  r_pe      <= 1'b0;
                  r_fe      <= 1'b0;
                  r_state   <= StStart;
               end
            end
            StStart: begin
               if (w_sample) r_state <= w_bit ? StIdle : StData;
            end
            StData: begin
               if (w_sample) begin
                  r_shift <= {w_bit, r_shift[WIDTH-1:1]};
                  r_par   <= r_par ^ w_bit;
                  if (r_bit_cnt == LAST_DATA) begin
                     r_bit_cnt <= '0;
                     r_state   <= (PARITY != PARITY_NONE) ? StPar : StStop;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            StPar: begin
               if (w_sample) begin
                  r_pe    <= (PARITY == PARITY_EVEN) ? (r_par ^ w_bit) : ~(r_par ^ w_bit);
                  r_state <= StStop;
               end
            end
            StStop: begin
               if (w_sample) begin
                  if (!w_bit) r_fe <= 1'b1;
                  if (r_bit_cnt == LAST_STOP) begin
                     r_bit_cnt <= '0;
                     r_state   <= StCommit;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            StCommit: begin
               // Accepting in this same cycle frees the slot for the new word.
               if (!valid || ready) begin
                  data_out   <= r_shift;
                  parity_err <= r_pe;
                  frame_err  <= r_fe;
                  valid      <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy = (r_state != StIdle);

endmodule
